led_event_scheduler: RTL and testbench
======================================

# led_event_scheduler

Sequencer between the key function decoder (single/long/double-click event pulses) and the LED driver. Buffers click events in a small FIFO and plays them back one at a time as timed LED indications, separated by a dark gap, so bursts of clicks are never merged or lost silently. Instantiated in the click-demo top level in place of the direct decoder-to-LED connection.

## Interface
- HOLD_CYCLES, 5_000_000, clock cycles an LED indication stays lit (100 ms at 50 MHz); minimum 1
- GAP_CYCLES, 1_000_000, dark cycles after each indication; minimum 1
- FIFO_DEPTH, 4, event buffer entries; power of two, 2..16
- CLOCK  input  1  system clock, rising edge
- RST_n  input  1  asynchronous, active-low reset
- Pin_In  input  3  one-cycle event pulses from the decoder: bit0 single, bit1 long, bit2 double
- LED  output  3  one-hot indication, same bit mapping as Pin_In; 0 when idle or in gap
- Busy_Sig  output  1  high while FIFO non-empty or FSM not IDLE
- Drop_Sig  output  1  one-cycle pulse when an event is discarded

## Operation
- Event capture, each cycle Pin_In != 0: encode to 2-bit code by priority double > long > single; lower-priority bits of the same cycle are discarded and raise Drop_Sig.
- Push: code written into FIFO if not full, or if full and a pop occurs the same cycle. Otherwise event discarded, Drop_Sig pulses.
- FSM states IDLE, SHOW, GAP:
  - IDLE: FIFO non-empty -> pop head, LED <= one-hot(code), counter <= HOLD_CYCLES-1, go SHOW. Empty -> stay, LED = 0.
  - SHOW: counter decrements; at 0 -> LED <= 0, counter <= GAP_CYCLES-1, go GAP.
  - GAP: counter decrements; at 0 -> IDLE.
- Counter width = clog2(max(HOLD_CYCLES, GAP_CYCLES)); no wrap, reloaded on every state entry.
- FIFO order strictly preserved; no event is reordered or coalesced.

## Timing
- Reset (asynchronous assert, synchronous-to-CLOCK release): LED = 0, Busy_Sig = 0, Drop_Sig = 0, FSM IDLE, FIFO empty, counter 0.
- Reset mid-indication: LED drops to 0 immediately; all queued events lost, no Drop_Sig.
- Latency: event sampled at edge k (written to FIFO), popped at edge k+1; LED high from edge k+1 for exactly HOLD_CYCLES cycles, then low exactly GAP_CYCLES cycles before the next pop.
- Back-to-back queued events: LED period = HOLD_CYCLES + GAP_CYCLES + 1 (1 IDLE cycle).
- Busy_Sig registered: rises at the edge after the first push, falls in the cycle IDLE is re-entered with FIFO empty.
- Drop_Sig registered, one cycle, asserted the edge after the discarding sample.

## Configuration
- LED_SCHED_DROP_COUNT_EN defined: adds output Drop_Count (8 bits), saturating count of discarded events, cleared only by reset; stays 255 once reached.
- Not defined: port and counter absent; Drop_Sig still present.

## Structure
- Shared package led_sched_pkg: event codes (EV_SINGLE=0, EV_LONG=1, EV_DOUBLE=2), FSM state encoding, one-hot decode function.
- Sub-module sched_fifo: synchronous FIFO, parameter DEPTH, width 2, ports push/pop/din/dout/full/empty, read-before-write when full with simultaneous push/pop.
- Top contains encoder, FSM, hold/gap counter, drop logic.

## Test plan
Bench parameters HOLD_CYCLES=4, GAP_CYCLES=2, FIFO_DEPTH=4.
- Single pulse Pin_In=3'b001 at edge 10 -> LED=3'b001 on edges 11..14, 0 on 15..16, Busy_Sig low from edge 17.
- Pin_In=3'b101 one cycle -> LED=3'b100 for 4 cycles, Drop_Sig pulses once.
- Six pulses long,single,double,long,single,double on consecutive cycles -> first popped immediately, next four queued, sixth dropped (one Drop_Sig); LED shows long,single,double,long,single at 7-cycle period.
- Pulse arriving in same cycle as a pop with FIFO full -> accepted, no Drop_Sig, order preserved.
- RST_n low during SHOW with 3 queued -> LED=0 asynchronously; after release no LED activity, Busy_Sig=0.
- With LED_SCHED_DROP_COUNT_EN: 300 drops -> Drop_Count=255; reset -> 0.

Source files
------------

// File: rtl/led_sched_pkg.sv
// Shared types for the LED event scheduler: event codes, FSM states, helpers.
package led_sched_pkg;

  localparam int unsigned EV_W  = 2;
  localparam int unsigned LED_W = 3;

  typedef enum logic [1:0] {
    EV_SINGLE = 2'd0,
    EV_LONG   = 2'd1,
    EV_DOUBLE = 2'd2
  } ev_code_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_e;

  // One-hot LED pattern for an event code (bit mapping matches Pin_In).
  function automatic logic [LED_W-1:0] ev_onehot(input logic [EV_W-1:0] code);
    logic [LED_W-1:0] led;
    led = '0;
    case (code)
      EV_SINGLE: led = 3'b001;
      EV_LONG:   led = 3'b010;
      EV_DOUBLE: led = 3'b100;
      default:   led = '0;
    endcase
    return led;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sched_fifo.sv
// Small show-ahead FIFO of event codes; a push into a full FIFO is accepted
// only when a pop happens in the same cycle (head read before overwrite).
module sched_fifo
  import led_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [EV_W-1:0] din,
  output logic [EV_W-1:0] dout,
  output logic            full,
  output logic            empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [EV_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_d;
  logic            do_push;
  logic            do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_d = count;
    case ({do_push, do_pop})
      2'b10:   count_d = count + CW'(1);
      2'b01:   count_d = count - CW'(1);
      default: count_d = count;
    endcase
  end

  // Pointers, occupancy and registered flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_d;
      full  <= (count_d == CW'(DEPTH));
      empty <= (count_d == '0);
    end
  end

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/led_event_scheduler.sv
// Queues decoder click events and plays them back as timed one-hot LED
// indications separated by a dark gap.
// Optional: define LED_SCHED_DROP_COUNT_EN to add the saturating Drop_Count output.
module led_event_scheduler
  import led_sched_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 5_000_000,
  parameter int unsigned GAP_CYCLES  = 1_000_000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic             CLOCK,
  input  logic             RST_n,
  input  logic [LED_W-1:0] Pin_In,
  output logic [LED_W-1:0] LED,
  output logic             Busy_Sig,
  output logic             Drop_Sig
`ifdef LED_SCHED_DROP_COUNT_EN
  ,
  output logic [7:0]       Drop_Count
`endif
);

  localparam int unsigned CNT_MAX = max_u(HOLD_CYCLES, GAP_CYCLES);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LED_W-1:0] led_d;
  logic             busy_d;
  logic             pop_c;
  logic             push_c;
  logic             ev_valid_c;
  logic [EV_W-1:0]  ev_code_c;
  logic [1:0]       lower_drop_c;
  logic [1:0]       drop_n_c;
  logic [EV_W-1:0]  fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;

  // Priority encoder: double > long > single; lower bits of the same cycle are discarded.
  always_comb begin
    ev_valid_c   = |Pin_In;
    ev_code_c    = EV_SINGLE;
    lower_drop_c = 2'd0;
    if (Pin_In[2]) begin
      ev_code_c    = EV_DOUBLE;
      lower_drop_c = 2'(Pin_In[1]) + 2'(Pin_In[0]);
    end else if (Pin_In[1]) begin
      ev_code_c    = EV_LONG;
      lower_drop_c = 2'(Pin_In[0]);
    end
  end

  // Accept when there is room, or when the head leaves in the same cycle.
  always_comb begin
    push_c   = ev_valid_c && (!fifo_full || pop_c);
    drop_n_c = lower_drop_c + 2'(ev_valid_c && !push_c);
  end

  sched_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLOCK),
    .rst_n (RST_n),
    .push  (push_c),
    .pop   (pop_c),
    .din   (ev_code_c),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state, counter and LED decode for IDLE -> SHOW -> GAP playback.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    led_d   = LED;
    pop_c   = 1'b0;
    case (state_q)
      IDLE: begin
        led_d = '0;
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          led_d   = ev_onehot(fifo_dout);
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (cnt_q == '0) begin
          led_d   = '0;
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        led_d = '0;
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        led_d   = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE) || !fifo_empty;
  end

  // State, counter and registered outputs.
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      LED      <= '0;
      Busy_Sig <= 1'b0;
      Drop_Sig <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      LED      <= led_d;
      Busy_Sig <= busy_d;
      Drop_Sig <= (drop_n_c != 2'd0);
    end
  end

`ifdef LED_SCHED_DROP_COUNT_EN
  logic [8:0] drop_sum_c;

  assign drop_sum_c = {1'b0, Drop_Count} + 9'(drop_n_c);

  // Saturating count of every discarded event, cleared only by reset.
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      Drop_Count <= '0;
    end else begin
      Drop_Count <= drop_sum_c[8] ? 8'hFF : drop_sum_c[7:0];
    end
  end
`endif

endmodule

// File: tb/tb_led_event_scheduler.sv
// Scoreboard bench for led_event_scheduler (HOLD=4, GAP=2, DEPTH=4).
module tb_led_event_scheduler;

  localparam int unsigned HOLD  = 4;
  localparam int unsigned GAP   = 2;
  localparam int unsigned DEPTH = 4;

  logic       CLOCK = 1'b0;
  logic       RST_n = 1'b0;
  logic [2:0] Pin_In = 3'b000;
  logic [2:0] LED;
  logic       Busy_Sig;
  logic       Drop_Sig;
`ifdef LED_SCHED_DROP_COUNT_EN
  logic [7:0] Drop_Count;
`endif

  led_event_scheduler #(
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .CLOCK      (CLOCK),
    .RST_n      (RST_n),
    .Pin_In     (Pin_In),
    .LED        (LED),
    .Busy_Sig   (Busy_Sig),
`ifdef LED_SCHED_DROP_COUNT_EN
    .Drop_Sig   (Drop_Sig),
    .Drop_Count (Drop_Count)
`else
    .Drop_Sig   (Drop_Sig)
`endif
  );

  always #5 CLOCK = ~CLOCK;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int drop_seen = 0;
  bit sb_on = 1'b1;
  logic [2:0] exp_q[$];
  int starts[$];

  always @(posedge CLOCK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the expected code at every LED indication and checks its timing.
  logic [2:0] led_prev = 3'b000;
  int hold_cnt = 0;
  int gap_cnt = 0;
  bit seen_fall = 1'b0;

  always @(negedge CLOCK) begin
    if (!RST_n) begin
      led_prev  = 3'b000;
      hold_cnt  = 0;
      gap_cnt   = 0;
      seen_fall = 1'b0;
    end else begin
      if (Drop_Sig) drop_seen++;
      if (sb_on) begin
        if (LED != 3'b000 && led_prev == 3'b000) begin
          starts.push_back(cyc);
          if (seen_fall) begin
            tests++;
            if (gap_cnt < int'(GAP + 1)) begin
              fails++;
              $display("FAIL gap_len: got %0d dark cycles required at least %0d", gap_cnt, GAP + 1);
            end
          end
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL led_unexpected: got LED=%b required no indication", LED);
          end else begin
            chk("led_code", 32'(LED), 32'(exp_q.pop_front()));
          end
          hold_cnt = 1;
        end else if (LED != 3'b000) begin
          hold_cnt++;
        end else if (led_prev != 3'b000) begin
          chk("hold_len", hold_cnt, HOLD);
          gap_cnt   = 1;
          seen_fall = 1'b1;
        end else begin
          gap_cnt++;
        end
      end
      led_prev = LED;
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    repeat (3) @(negedge CLOCK);
    while ((Busy_Sig || LED != 3'b000) && n < 300) begin
      @(negedge CLOCK);
      n++;
    end
    tests++;
    if (n >= 300) begin
      fails++;
      $display("FAIL %s: got busy after %0d cycles required idle", name, n);
    end
    repeat (3) @(negedge CLOCK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int act;

    // Reset state
    #1;
    chk("rst_led", 32'(LED), 0);
    chk("rst_busy", 32'(Busy_Sig), 0);
    chk("rst_drop", 32'(Drop_Sig), 0);
`ifdef LED_SCHED_DROP_COUNT_EN
    chk("rst_drop_count", 32'(Drop_Count), 0);
`endif
    repeat (2) @(negedge CLOCK);
    RST_n = 1'b1;
    repeat (3) @(negedge CLOCK);

    // Single pulse: LED for 4 cycles, 2 dark, Busy falls on IDLE re-entry
    d0 = drop_seen;
    exp_q.push_back(3'b001);
    Pin_In = 3'b001;
    @(negedge CLOCK);
    Pin_In = 3'b000;
    chk("t1_led_k", 32'(LED), 0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge CLOCK);
      chk("t1_led_on", 32'(LED), 1);
      chk("t1_busy_on", 32'(Busy_Sig), 1);
    end
    for (int i = 5; i <= 6; i++) begin
      @(negedge CLOCK);
      chk("t1_led_gap", 32'(LED), 0);
      chk("t1_busy_gap", 32'(Busy_Sig), 1);
    end
    @(negedge CLOCK);
    chk("t1_busy_fall", 32'(Busy_Sig), 0);
    wait_idle("t1_idle");
    chk("t1_drops", drop_seen - d0, 0);

    // Simultaneous double + single: double shown, single dropped
    d0 = drop_seen;
    exp_q.push_back(3'b100);
    @(negedge CLOCK);
    Pin_In = 3'b101;
    @(negedge CLOCK);
    Pin_In = 3'b000;
    wait_idle("t2_idle");
    chk("t2_drops", drop_seen - d0, 1);

    // Six consecutive pulses: one shown, four queued, sixth dropped
    d0 = drop_seen;
    starts.delete();
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b001);
    @(negedge CLOCK);
    Pin_In = 3'b010; @(negedge CLOCK);
    Pin_In = 3'b001; @(negedge CLOCK);
    Pin_In = 3'b100; @(negedge CLOCK);
    Pin_In = 3'b010; @(negedge CLOCK);
    Pin_In = 3'b001; @(negedge CLOCK);
    Pin_In = 3'b100; @(negedge CLOCK);
    Pin_In = 3'b000;
    wait_idle("t3_idle");
    chk("t3_drops", drop_seen - d0, 1);
    chk("t3_shown", starts.size(), 5);
    for (int i = 1; i < 5; i++) begin
      act = (i < starts.size()) ? starts[i] - starts[i-1] : -1;
      chk("t3_period", act, HOLD + GAP + 1);
    end
`ifdef LED_SCHED_DROP_COUNT_EN
    chk("t3_drop_count", 32'(Drop_Count), 2);
`endif

    // Push into a full FIFO on the same edge as a pop: accepted, order kept
    d0 = drop_seen;
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b010);
    @(negedge CLOCK);
    Pin_In = 3'b001; @(negedge CLOCK);
    Pin_In = 3'b100; @(negedge CLOCK);
    Pin_In = 3'b010; @(negedge CLOCK);
    Pin_In = 3'b001; @(negedge CLOCK);
    Pin_In = 3'b100; @(negedge CLOCK);
    Pin_In = 3'b000;
    repeat (3) @(negedge CLOCK);
    Pin_In = 3'b010; @(negedge CLOCK);
    Pin_In = 3'b000;
    wait_idle("t4_idle");
    chk("t4_drops", drop_seen - d0, 0);

    // Reset during SHOW with three events queued
    d0 = drop_seen;
    exp_q.push_back(3'b001);
    @(negedge CLOCK);
    Pin_In = 3'b001; @(negedge CLOCK);
    Pin_In = 3'b010; @(negedge CLOCK);
    Pin_In = 3'b100; @(negedge CLOCK);
    Pin_In = 3'b001; @(negedge CLOCK);
    Pin_In = 3'b000;
    #2;
    RST_n = 1'b0;
    #1;
    chk("t5_led_async", 32'(LED), 0);
    chk("t5_busy_async", 32'(Busy_Sig), 0);
    chk("t5_drop_async", 32'(Drop_Sig), 0);
    exp_q.delete();
    repeat (2) @(negedge CLOCK);
    #2;
    RST_n = 1'b1;
    act = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLOCK);
      if (LED != 3'b000 || Busy_Sig) act++;
    end
    chk("t5_quiet_cycles", act, 0);
    chk("t5_busy", 32'(Busy_Sig), 0);
    chk("t5_drops", drop_seen - d0, 0);
`ifdef LED_SCHED_DROP_COUNT_EN
    chk("t5_drop_count", 32'(Drop_Count), 0);

    // Saturating drop counter, cleared by reset
    sb_on = 1'b0;
    Pin_In = 3'b011;
    repeat (310) @(negedge CLOCK);
    Pin_In = 3'b000;
    @(negedge CLOCK);
    chk("t6_drop_count_sat", 32'(Drop_Count), 255);
    #2;
    RST_n = 1'b0;
    #1;
    chk("t6_drop_count_rst", 32'(Drop_Count), 0);
    exp_q.delete();
    repeat (2) @(negedge CLOCK);
    #2;
    RST_n = 1'b1;
    @(negedge CLOCK);
    sb_on = 1'b1;
    chk("t6_drop_count_after", 32'(Drop_Count), 0);
`endif

    repeat (5) @(negedge CLOCK);
    chk("end_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
